// File: rtl/alu_if.sv
// Nibble ALU bus: operand/control bundle in, result/carry bundle out.
// alu_pkg holds the shared command and bundle types.
package alu_pkg;
    typedef enum logic [2:0] {
        CMD_ADD   = 3'd0,
        CMD_AND   = 3'd1,
        CMD_OR    = 3'd2,
        CMD_XOR   = 3'd3,
        CMD_RSHFT = 3'd4,
        CMD_LSHFT = 3'd5
    } alu_cmd_e;

    typedef struct packed {
        alu_cmd_e cmd;
        logic     carry_in;
        logic     b_inv;
        logic     carry_disable;
    } alu_ctrl_t;

    typedef struct packed {
        alu_ctrl_t  ctrl;
        logic [3:0] d1;
        logic [3:0] d2;
    } alu_args_t;

    typedef struct packed {
        logic [3:0] res;
        logic       carry_out;
    } alu_ret_t;
endpackage

interface alu_if;
    import alu_pkg::*;

    alu_args_t args;
    alu_ret_t  ret;

    modport master (output args, input ret);
    modport slave  (input args, output ret);
endinterface

// File: rtl/alu.sv
// Single-nibble ALU slice with registered carry/zero status.
// Define ALU_OUTPUT_REG_EN to register ret.res/ret.carry_out (1-cycle latency).
module alu
    import alu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    alu_if.slave bus,
    input  logic flags_en,
    output logic carry_q,
    output logic zero_q
);

    logic [3:0] b;
    logic       ci;
    logic [4:0] sum;
    logic [3:0] comb_res;
    logic       comb_co;

    // d1 only reaches the result through ADD/logic ops, so an unknown d1
    // during a shift never leaks into res or carry_out.
    always_comb begin
        b        = bus.args.ctrl.b_inv ? ~bus.args.d2 : bus.args.d2;
        ci       = bus.args.ctrl.carry_disable ? 1'b0 : bus.args.ctrl.carry_in;
        sum      = {1'b0, bus.args.d1} + {1'b0, b} + {4'b0000, ci};
        comb_res = 4'h0;
        comb_co  = 1'b0;
        case (bus.args.ctrl.cmd)
            CMD_ADD: begin
                comb_res = sum[3:0];
                comb_co  = sum[4];
            end
            CMD_AND: comb_res = bus.args.d1 & b;
            CMD_OR:  comb_res = bus.args.d1 | b;
            CMD_XOR: comb_res = bus.args.d1 ^ b;
            CMD_RSHFT: begin
                comb_res = {ci, b[3:1]};
                comb_co  = b[0];
            end
            CMD_LSHFT: begin
                comb_res = {b[2:0], ci};
                comb_co  = b[3];
            end
            default: begin
                comb_res = 4'h0;
                comb_co  = 1'b0;
            end
        endcase
    end

`ifdef ALU_OUTPUT_REG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ret.res       <= 4'h0;
            bus.ret.carry_out <= 1'b0;
        end else begin
            bus.ret.res       <= comb_res;
            bus.ret.carry_out <= comb_co;
        end
    end
`else
    assign bus.ret.res       = comb_res;
    assign bus.ret.carry_out = comb_co;
`endif

    // Status samples the current-cycle ALU result; reset dominates flags_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
        end else if (flags_en) begin
            carry_q <= comb_co;
            zero_q  <= (comb_res == 4'h0);
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed scoreboard bench for the nibble ALU and its status registers.
module tb_alu;
    import alu_pkg::*;

    typedef struct packed {
        logic [3:0] res;
        logic       co;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flags_en;
    logic carry_q;
    logic zero_q;

    alu_if bus_if ();

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if.slave),
        .flags_en (flags_en),
        .carry_q  (carry_q),
        .zero_q   (zero_q)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    logic exp_c, exp_z;
    logic pend_c, pend_z;

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkNibble(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one operation at the falling edge and push its expected result
    task automatic applyStimulus(input logic [2:0] cmd, input logic cin, input logic binv,
                                 input logic cdis, input logic [3:0] d1, input logic [3:0] d2,
                                 input logic flg);
        int   bv, c, s;
        exp_t e;
        @(negedge clk);
        bus_if.args.ctrl.cmd           = alu_cmd_e'(cmd);
        bus_if.args.ctrl.carry_in      = cin;
        bus_if.args.ctrl.b_inv         = binv;
        bus_if.args.ctrl.carry_disable = cdis;
        bus_if.args.d1                 = d1;
        bus_if.args.d2                 = d2;
        flags_en                       = flg;
        bv = binv ? (15 - int'(d2)) : int'(d2);
        c  = cdis ? 0 : int'(cin);
        e  = '0;
        case (cmd)
            3'd0: begin
                s     = int'(d1) + bv + c;
                e.res = 4'(s % 16);
                e.co  = (s >= 16);
            end
            3'd1: e.res = d1 & 4'(bv);
            3'd2: e.res = d1 | 4'(bv);
            3'd3: e.res = d1 ^ 4'(bv);
            3'd4: begin
                e.res = 4'(c * 8 + bv / 2);
                e.co  = (bv % 2) == 1;
            end
            3'd5: begin
                e.res = 4'((bv * 2 + c) % 16);
                e.co  = bv >= 8;
            end
            default: e = '0;
        endcase
        sb.push_back(e);
        pend_c = e.co;
        pend_z = (e.res == 4'h0);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s: observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb.pop_front();
            checkNibble({tag, ".res"}, bus_if.ret.res, e.res);
            checkBit({tag, ".carry_out"}, bus_if.ret.carry_out, e.co);
        end
    endtask

    // Advance one rising edge and compare the status registers to the model
    task automatic clockStatus(input string tag);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_c = 1'b0;
            exp_z = 1'b1;
        end else if (flags_en) begin
            exp_c = pend_c;
            exp_z = pend_z;
        end
        checkBit({tag, ".carry_q"}, carry_q, exp_c);
        checkBit({tag, ".zero_q"}, zero_q, exp_z);
    endtask

    task automatic runStep(input string tag, input logic [2:0] cmd, input logic cin,
                           input logic binv, input logic cdis, input logic [3:0] d1,
                           input logic [3:0] d2, input logic flg);
        applyStimulus(cmd, cin, binv, cdis, d1, d2, flg);
`ifdef ALU_OUTPUT_REG_EN
        clockStatus(tag);
        checkOutput(tag);
`else
        #1;
        checkOutput(tag);
        clockStatus(tag);
`endif
    endtask

    initial begin
        rst      = 1'b1;
        flags_en = 1'b0;
        bus_if.args = '0;
        exp_c    = 1'b0;
        exp_z    = 1'b1;
        pend_c   = 1'b0;
        pend_z   = 1'b1;
        #3;
        checkBit("reset.carry_q", carry_q, 1'b0);
        checkBit("reset.zero_q", zero_q, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        //       tag             cmd   cin  binv cdis d1     d2     flg
        runStep("add_4_4",      3'd0, 0,   0,   0,   4'h4,  4'h4,  1);
        runStep("add_f_1",      3'd0, 0,   0,   0,   4'hF,  4'h1,  1);
        runStep("add_binv",     3'd0, 0,   1,   0,   4'h0,  4'h0,  0);
        runStep("add_cdis",     3'd0, 1,   0,   1,   4'h2,  4'h3,  0);
        runStep("sub_5_3",      3'd0, 1,   1,   0,   4'h5,  4'h3,  1);
        runStep("rshft_6_x",    3'd4, 0,   0,   0,   4'bx,  4'h6,  0);
        runStep("rshft_1_ci",   3'd4, 1,   0,   0,   4'h0,  4'h1,  0);
        runStep("lshft_9_ci",   3'd5, 1,   0,   0,   4'bx,  4'h9,  1);
        runStep("xor_a_f",      3'd3, 0,   0,   0,   4'hA,  4'hF,  0);
        runStep("and_c_a",      3'd1, 0,   0,   0,   4'hC,  4'hA,  0);
        runStep("or_c_a",       3'd2, 0,   0,   0,   4'hC,  4'hA,  0);
        runStep("and_binv",     3'd1, 0,   1,   0,   4'hF,  4'h5,  0);
        runStep("cmd7",         3'd7, 1,   0,   0,   4'hF,  4'hF,  1);
        runStep("add_f_2",      3'd0, 0,   0,   0,   4'hF,  4'h2,  1);

        // Reset between edges with flags_en high must clear status immediately
        applyStimulus(3'd0, 0, 0, 0, 4'hF, 4'h2, 1);
        #2;
        rst = 1'b1;
        #1;
        checkBit("midrst.carry_q", carry_q, 1'b0);
        checkBit("midrst.zero_q", zero_q, 1'b1);
        exp_c = 1'b0;
        exp_z = 1'b1;
        clockStatus("midrst_hold1");
        clockStatus("midrst_hold2");
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        clockStatus("after_rst");

        $display("[TB] directed sequence complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
